dmem_access_controller: RTL
===========================

# dmem_access_controller

MEM-stage data-memory access controller sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. Takes load/store requests from EX/MEM, runs a multi-cycle handshake with main data memory, aligns store data into byte lanes, extracts and sign/zero-extends load data, and drives `BUSYWAIT` to stall all pipeline registers until the access completes. `OUT_DMEM_OUT` feeds the MEM/WB `IN_DMEM_OUT` input directly.

## Interface
Parameters: none; all widths are fixed for RV32.

Ports:
- `CLK`  in  1  system clock, rising edge
- `RESET`  in  1  synchronous, active-high
- `IN_MEM_READ`  in  1  load request from EX/MEM
- `IN_MEM_WRITE`  in  1  store request from EX/MEM
- `IN_FUNC3`  in  3  access type
  - `000` LB/SB; `001` LH/SH; `010` LW/SW; `100` LBU; `101` LHU
  - other codes are treated as word
- `IN_ADDRESS`  in  32  byte address (ALU result)
- `IN_WRITE_DATA`  in  32  store data (rs2 value)
- `OUT_DMEM_OUT`  out  32  extended load result, registered
- `BUSYWAIT`  out  1  pipeline stall, combinational
- `MAIN_MEM_READ`  out  1  memory read strobe
- `MAIN_MEM_WRITE`  out  1  memory write strobe
- `MAIN_MEM_ADDRESS`  out  30  word address, equal to `IN_ADDRESS[31:2]`
- `MAIN_MEM_WRITEDATA`  out  32  lane-replicated store data
- `MAIN_MEM_BYTE_EN`  out  4  store byte enables
- `MAIN_MEM_READDATA`  in  32  read word from memory
- `MAIN_MEM_BUSYWAIT`  in  1  high while memory is busy with the current strobe

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE
  - If `IN_MEM_READ` or `IN_MEM_WRITE` is high: `BUSYWAIT`=1 in the same cycle; next state is ACCESS.
  - Otherwise `BUSYWAIT`=0 and the state stays IDLE.
- ACCESS
  - Drives `MAIN_MEM_READ` or `MAIN_MEM_WRITE`, plus address, data and byte enables; `BUSYWAIT`=1.
  - Completes at a rising edge where `MAIN_MEM_BUSYWAIT`=0. On a read it captures the extended data into `OUT_DMEM_OUT`; next state is DONE.
  - While `MAIN_MEM_BUSYWAIT`=1 the state stays ACCESS with the strobe held.
- DONE
  - `BUSYWAIT`=0 and strobes low. The pipeline advances at the end of this cycle and MEM/WB captures `OUT_DMEM_OUT`.
  - Next state is always IDLE, so a back-to-back request is re-evaluated as a new access.
- If read and write are both high, the write wins and `OUT_DMEM_OUT` holds its value.
- Store byte enables:
  - SB: `4'b0001 << IN_ADDRESS[1:0]`
  - SH: `IN_ADDRESS[1]` ? `1100` : `0011`
  - SW: `1111`
- Store write data: SB replicates byte[7:0] ×4; SH replicates half[15:0] ×2; SW passes the word through.
- Load extraction:
  - Byte lane is selected by `IN_ADDRESS[1:0]`; half lane by `IN_ADDRESS[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Misaligned accesses are not trapped. Halfword accesses ignore `IN_ADDRESS[0]`; word accesses ignore `IN_ADDRESS[1:0]`.
- `MAIN_MEM_BYTE_EN` is `0000` whenever no write strobe is driven.

## Timing
- Reset: on a rising edge with `RESET`=1:
  - state becomes IDLE and `OUT_DMEM_OUT`=0;
  - strobes are 0 and `MAIN_MEM_BYTE_EN`=0;
  - `BUSYWAIT` is forced to 0 while `RESET` is high.
- Reset mid-ACCESS abandons the transaction: strobes drop after that edge and no data is captured.
- A zero-wait memory (`MAIN_MEM_BUSYWAIT`=0 throughout) gives `BUSYWAIT` high for exactly 2 cycles (IDLE and ACCESS), then DONE. Total MEM-stage occupancy is 3 cycles.
- Each cycle of `MAIN_MEM_BUSYWAIT`=1 during ACCESS adds one cycle of stall.
- `OUT_DMEM_OUT` changes only at a read-completion edge or on reset. It is stable throughout DONE and afterwards.
- Stores never alter `OUT_DMEM_OUT`.
- With no request, the block stays in IDLE with `BUSYWAIT`=0 and no memory traffic; it adds zero stall for non-memory instructions.

## Test plan
- Reset: hold `RESET`=1 for one edge while in ACCESS → after that edge `OUT_DMEM_OUT`=0, `BUSYWAIT`=0, both strobes 0, state IDLE.
- LW, zero-wait memory: addr `0x100`, `MAIN_MEM_READDATA`=`0x8000_00F0` → `BUSYWAIT` high for 2 cycles, `MAIN_MEM_ADDRESS`=`0x40`; in DONE `OUT_DMEM_OUT`=`0x8000_00F0` and `BUSYWAIT`=0.
- Load extension, readdata `0x80F1_7F82`:
  - LB at addr byte 3 → `0xFFFF_FF80`
  - LBU at addr byte 0 → `0x0000_0082`
  - LH at addr byte 2 → `0xFFFF_80F1`
  - LHU at addr byte 0 → `0x0000_7F82`
- Stores, write data `0x1234_5678`:
  - SB at addr `0x...2` → byte-en `0100`, writedata `0x7878_7878`
  - SH at addr `0x...2` → byte-en `1100`, writedata `0x5678_5678`
  - SW → byte-en `1111`; `OUT_DMEM_OUT` unchanged
- Wait states: `MAIN_MEM_BUSYWAIT`=1 for 3 cycles of ACCESS → `BUSYWAIT` high for 5 cycles and strobe held constant throughout; completes with the correct data.
- Back-to-back: LW then SW on consecutive instructions → IDLE re-entered between them; two distinct strobe pulses; the second access begins the cycle after DONE.

Source files
------------

// File: rtl/dmem_access_controller.sv
// MEM-stage data-memory access controller: runs the load/store handshake with main memory,
// lane-aligns store data, extends load data and stalls the pipeline until the access completes.
module dmem_access_controller (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_MEM_READ,
  input  logic        IN_MEM_WRITE,
  input  logic [2:0]  IN_FUNC3,
  input  logic [31:0] IN_ADDRESS,
  input  logic [31:0] IN_WRITE_DATA,
  output logic [31:0] OUT_DMEM_OUT,
  output logic        BUSYWAIT,
  output logic        MAIN_MEM_READ,
  output logic        MAIN_MEM_WRITE,
  output logic [29:0] MAIN_MEM_ADDRESS,
  output logic [31:0] MAIN_MEM_WRITEDATA,
  output logic [3:0]  MAIN_MEM_BYTE_EN,
  input  logic [31:0] MAIN_MEM_READDATA,
  input  logic        MAIN_MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  state_e      state_q;
  logic        mem_req;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  assign mem_req          = IN_MEM_READ | IN_MEM_WRITE;
  assign MAIN_MEM_ADDRESS = IN_ADDRESS[31:2];

  // Store lane steering; unknown func3 codes behave as a full word.
  always_comb begin
    store_be   = 4'b1111;
    store_data = IN_WRITE_DATA;
    case (IN_FUNC3)
      F3Byte: begin
        store_be   = 4'b0001 << IN_ADDRESS[1:0];
        store_data = {4{IN_WRITE_DATA[7:0]}};
      end
      F3Half: begin
        store_be   = IN_ADDRESS[1] ? 4'b1100 : 4'b0011;
        store_data = {2{IN_WRITE_DATA[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = IN_WRITE_DATA;
      end
    endcase
  end

  assign MAIN_MEM_WRITEDATA = store_data;

  // Load lane selection and extension; misaligned low address bits are ignored.
  always_comb begin
    load_byte = 8'h00;
    unique case (IN_ADDRESS[1:0])
      2'b00: load_byte = MAIN_MEM_READDATA[7:0];
      2'b01: load_byte = MAIN_MEM_READDATA[15:8];
      2'b10: load_byte = MAIN_MEM_READDATA[23:16];
      2'b11: load_byte = MAIN_MEM_READDATA[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = IN_ADDRESS[1] ? MAIN_MEM_READDATA[31:16] : MAIN_MEM_READDATA[15:0];
    load_ext  = MAIN_MEM_READDATA;
    case (IN_FUNC3)
      F3Byte:  load_ext = {{24{load_byte[7]}}, load_byte};
      F3Half:  load_ext = {{16{load_half[15]}}, load_half};
      F3ByteU: load_ext = {24'h000000, load_byte};
      F3HalfU: load_ext = {16'h0000, load_half};
      default: load_ext = MAIN_MEM_READDATA;
    endcase
  end

  // Stall covers the request cycle in idle and every access cycle.
  always_comb begin
    BUSYWAIT = 1'b0;
    if (!RESET) begin
      BUSYWAIT = (state_q == StAccess) || ((state_q == StIdle) && mem_req);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= StIdle;
      OUT_DMEM_OUT     <= 32'h0000_0000;
      MAIN_MEM_READ    <= 1'b0;
      MAIN_MEM_WRITE   <= 1'b0;
      MAIN_MEM_BYTE_EN <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req) begin
            state_q          <= StAccess;
            // Write takes priority when both requests are raised.
            MAIN_MEM_WRITE   <= IN_MEM_WRITE;
            MAIN_MEM_READ    <= IN_MEM_READ & ~IN_MEM_WRITE;
            MAIN_MEM_BYTE_EN <= IN_MEM_WRITE ? store_be : 4'b0000;
          end
        end
        StAccess: begin
          if (!MAIN_MEM_BUSYWAIT) begin
            state_q          <= StDone;
            MAIN_MEM_READ    <= 1'b0;
            MAIN_MEM_WRITE   <= 1'b0;
            MAIN_MEM_BYTE_EN <= 4'b0000;
            if (MAIN_MEM_READ) begin
              OUT_DMEM_OUT <= load_ext;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q          <= StIdle;
          MAIN_MEM_READ    <= 1'b0;
          MAIN_MEM_WRITE   <= 1'b0;
          MAIN_MEM_BYTE_EN <= 4'b0000;
        end
      endcase
    end
  end

endmodule
